// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus for regfile_wb_arbiter: ALU and load requesters, load-issue
// scoreboard updates, hazard check, and the register-file write port.
interface regfile_wb_arbiter_if;
   logic        alu_valid;
   logic [2:0]  alu_dest;
   logic [15:0] alu_data;
   logic        alu_hb;
   logic        alu_lb;
   logic        alu_ready;

   logic        ld_valid;
   logic [2:0]  ld_dest;
   logic [15:0] ld_data;
   logic        ld_hb;
   logic        ld_lb;
   logic        ld_ready;

   logic        ld_issue;
   logic [2:0]  ld_issue_dest;
   logic [2:0]  chk_a;
   logic [2:0]  chk_b;
   logic        hazard;
   logic [7:0]  busy;

   logic        rf_we;
   logic [2:0]  rf_dest;
   logic [15:0] rf_data;
   logic        rf_hb;
   logic        rf_lb;

   modport master (
      output alu_valid, alu_dest, alu_data, alu_hb, alu_lb,
      input  alu_ready,
      output ld_valid, ld_dest, ld_data, ld_hb, ld_lb,
      input  ld_ready,
      output ld_issue, ld_issue_dest, chk_a, chk_b,
      input  hazard, busy,
      input  rf_we, rf_dest, rf_data, rf_hb, rf_lb
   );

   modport slave (
      input  alu_valid, alu_dest, alu_data, alu_hb, alu_lb,
      output alu_ready,
      input  ld_valid, ld_dest, ld_data, ld_hb, ld_lb,
      output ld_ready,
      input  ld_issue, ld_issue_dest, chk_a, chk_b,
      output hazard, busy,
      output rf_we, rf_dest, rf_data, rf_hb, rf_lb
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load returns, with a
// load scoreboard. Define WB_HAZARD_BYPASS_EN to drop hazard during the clearing load.
module regfile_wb_arbiter #(
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_wb_arbiter_if.slave bus
);
   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] r_wait_cnt;
   logic          r_rf_we;
   logic [2:0]    r_rf_dest;
   logic [15:0]   r_rf_data;
   logic          r_rf_hb;
   logic          r_rf_lb;
   logic [7:0]    r_busy;

   logic          w_starve;
   logic          w_alu_ready;
   logic          w_ld_ready;
   logic          w_alu_xfer;
   logic          w_ld_xfer;
   logic [7:0]    w_busy_nxt;
   logic [7:0]    w_busy_chk;

   assign w_starve    = (r_wait_cnt == CW'(MAX_WAIT));
   assign w_ld_ready  = !(w_starve && bus.alu_valid);
   assign w_alu_ready = !bus.ld_valid || w_starve;
   assign w_alu_xfer  = bus.alu_valid && w_alu_ready;
   assign w_ld_xfer   = bus.ld_valid && w_ld_ready;

   // Clear before set so a same-register issue keeps the new load outstanding
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_ld_xfer)
         w_busy_nxt[bus.ld_dest] = 1'b0;
      if (bus.ld_issue)
         w_busy_nxt[bus.ld_issue_dest] = 1'b1;
   end

   always_comb begin
      w_busy_chk = r_busy;
`ifdef WB_HAZARD_BYPASS_EN
      if (w_ld_xfer)
         w_busy_chk[bus.ld_dest] = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (!bus.alu_valid || w_alu_xfer) begin
         r_wait_cnt <= '0;
      end else if (!w_starve) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we   <= 1'b0;
         r_rf_dest <= '0;
         r_rf_data <= '0;
         r_rf_hb   <= 1'b0;
         r_rf_lb   <= 1'b0;
      end else begin
         r_rf_we <= w_alu_xfer || w_ld_xfer;
         if (w_alu_xfer) begin
            r_rf_dest <= bus.alu_dest;
            r_rf_data <= bus.alu_data;
            r_rf_hb   <= bus.alu_hb;
            r_rf_lb   <= bus.alu_lb;
         end else if (w_ld_xfer) begin
            r_rf_dest <= bus.ld_dest;
            r_rf_data <= bus.ld_data;
            r_rf_hb   <= bus.ld_hb;
            r_rf_lb   <= bus.ld_lb;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign bus.alu_ready = w_alu_ready;
   assign bus.ld_ready  = w_ld_ready;
   assign bus.hazard    = w_busy_chk[bus.chk_a] | w_busy_chk[bus.chk_b];
   assign bus.busy      = r_busy;
   assign bus.rf_we     = r_rf_we;
   assign bus.rf_dest   = r_rf_dest;
   assign bus.rf_data   = r_rf_data;
   assign bus.rf_hb     = r_rf_hb;
   assign bus.rf_lb     = r_rf_lb;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (MAX_WAIT=3, default build without
// WB_HAZARD_BYPASS_EN); expected values are hand-computed constants.
module tb_regfile_wb_arbiter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   regfile_wb_arbiter_if u_if ();

   regfile_wb_arbiter #(.MAX_WAIT(3)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alu(input logic v, input logic [2:0] d, input logic [15:0] x,
                            input logic hb, input logic lb);
      u_if.alu_valid = v;
      u_if.alu_dest  = d;
      u_if.alu_data  = x;
      u_if.alu_hb    = hb;
      u_if.alu_lb    = lb;
   endtask

   task automatic drive_ld(input logic v, input logic [2:0] d, input logic [15:0] x,
                           input logic hb, input logic lb);
      u_if.ld_valid = v;
      u_if.ld_dest  = d;
      u_if.ld_data  = x;
      u_if.ld_hb    = hb;
      u_if.ld_lb    = lb;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      drive_alu(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      drive_ld(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      u_if.ld_issue      = 1'b0;
      u_if.ld_issue_dest = 3'd0;
      u_if.chk_a         = 3'd0;
      u_if.chk_b         = 3'd0;
      #2;
      check("rst_rf_we",    {15'd0, u_if.rf_we}, 16'd0);
      check("rst_busy",     {8'd0, u_if.busy}, 16'h0000);
      check("rst_hazard",   {15'd0, u_if.hazard}, 16'd0);
      check("rst_ld_ready", {15'd0, u_if.ld_ready}, 16'd1);
      check("rst_rf_data",  u_if.rf_data, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Lone ALU write
      tick();
      drive_alu(1'b1, 3'd5, 16'hA55A, 1'b1, 1'b0);
      #1;
      check("alu_ready_lone", {15'd0, u_if.alu_ready}, 16'd1);
      tick();
      drive_alu(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      check("alu_rf_we",   {15'd0, u_if.rf_we}, 16'd1);
      check("alu_rf_dest", {13'd0, u_if.rf_dest}, 16'd5);
      check("alu_rf_data", u_if.rf_data, 16'hA55A);
      check("alu_rf_hb",   {15'd0, u_if.rf_hb}, 16'd1);
      check("alu_rf_lb",   {15'd0, u_if.rf_lb}, 16'd0);

      // Idle: write port drops, payload holds
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("idle_we%0d", i),   {15'd0, u_if.rf_we}, 16'd0);
         check($sformatf("idle_dest%0d", i), {13'd0, u_if.rf_dest}, 16'd5);
         check($sformatf("idle_data%0d", i), u_if.rf_data, 16'hA55A);
      end

      // Contention: load wins 3 cycles, then starved ALU wins
      drive_alu(1'b1, 3'd1, 16'h1111, 1'b1, 1'b1);
      drive_ld(1'b1, 3'd6, 16'h2222, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("cont_ld_rdy%0d", i),  {15'd0, u_if.ld_ready}, 16'd1);
         check($sformatf("cont_alu_rdy%0d", i), {15'd0, u_if.alu_ready}, 16'd0);
         tick();
         check($sformatf("cont_ld_dest%0d", i), {13'd0, u_if.rf_dest}, 16'd6);
         check($sformatf("cont_ld_data%0d", i), u_if.rf_data, 16'h2222);
      end
      #1;
      check("starve_ld_rdy",  {15'd0, u_if.ld_ready}, 16'd0);
      check("starve_alu_rdy", {15'd0, u_if.alu_ready}, 16'd1);
      tick();
      check("starve_we",   {15'd0, u_if.rf_we}, 16'd1);
      check("starve_dest", {13'd0, u_if.rf_dest}, 16'd1);
      check("starve_data", u_if.rf_data, 16'h1111);
      check("cnt_clr_ld_rdy",  {15'd0, u_if.ld_ready}, 16'd1);
      check("cnt_clr_alu_rdy", {15'd0, u_if.alu_ready}, 16'd0);
      drive_alu(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      drive_ld(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      tick();

      // Scoreboard set and clear
      u_if.ld_issue      = 1'b1;
      u_if.ld_issue_dest = 3'd2;
      u_if.chk_a         = 3'd2;
      u_if.chk_b         = 3'd0;
      #1;
      check("sb_hazard_pre", {15'd0, u_if.hazard}, 16'd0);
      tick();
      u_if.ld_issue = 1'b0;
      check("sb_busy_set",   {8'd0, u_if.busy}, 16'h0004);
      check("sb_hazard_set", {15'd0, u_if.hazard}, 16'd1);
      drive_ld(1'b1, 3'd2, 16'hBEEF, 1'b0, 1'b1);
      #1;
      check("sb_hazard_ret", {15'd0, u_if.hazard}, 16'd1);
      tick();
      drive_ld(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      check("sb_ret_dest",   {13'd0, u_if.rf_dest}, 16'd2);
      check("sb_ret_data",   u_if.rf_data, 16'hBEEF);
      check("sb_ret_lb",     {15'd0, u_if.rf_lb}, 16'd1);
      check("sb_ret_hb",     {15'd0, u_if.rf_hb}, 16'd0);
      check("sb_busy_clr",   {8'd0, u_if.busy}, 16'h0000);
      check("sb_hazard_clr", {15'd0, u_if.hazard}, 16'd0);

      // Same-cycle set/clear
      u_if.ld_issue      = 1'b1;
      u_if.ld_issue_dest = 3'd3;
      tick();
      check("sc_busy3", {8'd0, u_if.busy}, 16'h0008);
      drive_ld(1'b1, 3'd3, 16'h3333, 1'b1, 1'b1);
      tick();
      check("sc_same", {8'd0, u_if.busy}, 16'h0008);
      u_if.ld_issue_dest = 3'd4;
      tick();
      u_if.ld_issue = 1'b0;
      drive_ld(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      check("sc_diff", {8'd0, u_if.busy}, 16'h0010);

      // ALU write with no byte lanes, to a busy register
      u_if.chk_a = 3'd4;
      drive_alu(1'b1, 3'd4, 16'h7777, 1'b0, 1'b0);
      tick();
      drive_alu(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      check("nolane_we",   {15'd0, u_if.rf_we}, 16'd1);
      check("nolane_hblb", {14'd0, u_if.rf_hb, u_if.rf_lb}, 16'd0);
      check("alu_busy",    {8'd0, u_if.busy}, 16'h0010);

      // Reset mid-write: clears without a clock edge
      drive_alu(1'b1, 3'd7, 16'hCAFE, 1'b1, 1'b1);
      tick();
      check("mid_we_pre", {15'd0, u_if.rf_we}, 16'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_we",     {15'd0, u_if.rf_we}, 16'd0);
      check("mid_rst_busy",   {8'd0, u_if.busy}, 16'h0000);
      check("mid_rst_hazard", {15'd0, u_if.hazard}, 16'd0);
      check("mid_rst_data",   u_if.rf_data, 16'h0000);
      drive_alu(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
